uart_hex_tx_formatter: RTL and testbench

Converts binary words into printable ASCII hex text and streams the characters, one byte at a time, into the AXI4-Stream byte input of the UART transmitter. It sits directly upstream of the UART TX stage. Debug and status logic can push a raw word and get one formatted console line such as "0x1234ABCD\r\n". Output is registered and fully backpressure-aware, so the UART can stall it for any number of bit times.

---
 rtl/uart_hex_tx_formatter_pkg.sv | 18 +
 rtl/uart_nibble_ascii.sv | 12 +
 rtl/uart_hex_tx_formatter.sv | 86 ++++++++
 tb/tb_uart_hex_tx_formatter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_hex_tx_formatter_pkg.sv
// uart_hex_tx_formatter_pkg: shared ASCII codes, FSM encoding and sizing helper for the hex formatter
package uart_hex_tx_formatter_pkg;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PFX0 = 3'd1;
  localparam logic [2:0] ST_PFX1 = 3'd2;
  localparam logic [2:0] ST_DIG  = 3'd3;
  localparam logic [2:0] ST_CR   = 3'd4;
  localparam logic [2:0] ST_LF   = 3'd5;
  function automatic int cnt_width(int word_width);
    return (word_width / 4 > 1) ? $clog2(word_width / 4) : 1;
  endfunction
endpackage

// File: rtl/uart_nibble_ascii.sv
// uart_nibble_ascii: combinational nibble to ASCII hex digit (nib_i, upper_i -> char_o)
module uart_nibble_ascii
  import uart_hex_tx_formatter_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       upper_i,
  output logic [7:0] char_o
);
  always_comb
    char_o = (nib_i < 4'd10) ? ASCII_ZERO + {4'b0, nib_i}
           : (upper_i ? ASCII_A_UC : ASCII_A_LC) + {4'b0, nib_i} - 8'd10;
endmodule

// File: rtl/uart_hex_tx_formatter.sv
// uart_hex_tx_formatter: streams a word as "0x<hex>\r\n" bytes (s_axis word in, m_axis byte out, busy)
module uart_hex_tx_formatter
  import uart_hex_tx_formatter_pkg::*;
#(
  parameter int   WORD_WIDTH = 32,
  parameter logic PREFIX_EN  = 1'b1,
  parameter logic NEWLINE_EN = 1'b1,
  parameter logic UPPERCASE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy
);
  localparam int NDIG = WORD_WIDTH / 4;
  localparam int CW = cnt_width(WORD_WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(NDIG - 1);
  logic [2:0] state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] tdata_q, tdata_d;
  logic tvalid_q, tvalid_d;
  logic [7:0] dig_char, char_sel;
  logic slot_free;
  // the word shifts left once per digit, so the current digit is always the top nibble
  uart_nibble_ascii u_nib (
    .nib_i  (word_q[WORD_WIDTH-1 -: 4]),
    .upper_i(UPPERCASE),
    .char_o (dig_char)
  );
  assign slot_free = !tvalid_q || m_axis_tready;
  assign char_sel = (state_q == ST_PFX0) ? ASCII_ZERO
                  : (state_q == ST_PFX1) ? ASCII_X
                  : (state_q == ST_DIG)  ? dig_char
                  : (state_q == ST_CR)   ? ASCII_CR : ASCII_LF;
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (state_q == ST_IDLE) begin
      if (slot_free) tvalid_d = 1'b0;
      if (s_axis_tvalid) begin
        word_d  = s_axis_tdata;
        cnt_d   = CNT_TOP;
        state_d = PREFIX_EN ? ST_PFX0 : ST_DIG;
      end
    end else if (slot_free) begin
      tdata_d  = char_sel;
      tvalid_d = 1'b1;
      state_d  = (state_q == ST_PFX0) ? ST_PFX1
               : (state_q == ST_PFX1) ? ST_DIG
               : (state_q == ST_DIG)  ? ((cnt_q != '0) ? ST_DIG : NEWLINE_EN ? ST_CR : ST_IDLE)
               : (state_q == ST_CR)   ? ST_LF : ST_IDLE;
      if (state_q == ST_DIG) begin
        word_d = word_q << 4;
        cnt_d  = cnt_q - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end
  assign s_axis_tready = (state_q == ST_IDLE) && !rst;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != ST_IDLE) || tvalid_q;
endmodule

// File: tb/tb_uart_hex_tx_formatter.sv
// tb_uart_hex_tx_formatter: scoreboard bench for three formatter configurations
module tb_uart_hex_tx_formatter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] s_tdata [3];
  logic        s_tvalid[3];
  logic        s_tready[3];
  logic [7:0]  m_tdata [3];
  logic        m_tvalid[3];
  logic        m_tready[3];
  logic        busy    [3];
  logic [7:0]  exp_q[3][$];
  int          hs    [3];
  bit          stall [3];
  logic [7:0]  held  [3];
  int          ww [3] = '{32, 32, 8};
  bit          pfx[3] = '{1, 1, 0};
  bit          nl [3] = '{1, 1, 0};
  bit          uc [3] = '{1, 0, 1};
  int n_chk = 0;
  int n_pass = 0;
  uart_hex_tx_formatter u_def (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .busy(busy[0])
  );
  uart_hex_tx_formatter #(.UPPERCASE(1'b0)) u_lc (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .busy(busy[1])
  );
  uart_hex_tx_formatter #(.WORD_WIDTH(8), .PREFIX_EN(1'b0), .NEWLINE_EN(1'b0)) u_w8 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[2][7:0]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
    .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]),
    .busy(busy[2])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic void push_word(input int k, input logic [31:0] w);
    string hx = uc[k] ? "0123456789ABCDEF" : "0123456789abcdef";
    if (pfx[k]) begin
      exp_q[k].push_back(8'h30);
      exp_q[k].push_back(8'h78);
    end
    for (int i = ww[k] / 4 - 1; i >= 0; i--) exp_q[k].push_back(hx[w[i*4 +: 4]]);
    if (nl[k]) begin
      exp_q[k].push_back(8'h0D);
      exp_q[k].push_back(8'h0A);
    end
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) stall[k] <= 1'b0;
      else begin
        if (stall[k]) begin
          chk("hold valid", m_tvalid[k], 1);
          chk("hold data", m_tdata[k], held[k]);
        end
        if (m_tvalid[k] && m_tready[k]) begin
          chk("queue nonempty", exp_q[k].size() != 0, 1);
          if (exp_q[k].size() != 0) chk("char", m_tdata[k], exp_q[k].pop_front());
          hs[k] <= hs[k] + 1;
        end
        stall[k] <= m_tvalid[k] && !m_tready[k];
        held[k]  <= m_tdata[k];
      end
    end
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int k, input logic [31:0] w, input bit hold);
    bit got = 1'b0;
    s_tdata[k]  = w;
    s_tvalid[k] = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = s_tready[k];
    end
    chk("accept", got, 1);
    if (got) push_word(k, w);
    @(posedge clk);
    #1;
    if (!hold) s_tvalid[k] = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base;
    for (int k = 0; k < 3; k++) begin
      s_tdata[k] = '0;
      s_tvalid[k] = 1'b0;
      m_tready[k] = 1'b1;
      hs[k] = 0;
    end
    wait_cyc(3);
    for (int k = 0; k < 3; k++) begin
      chk("rst tvalid", m_tvalid[k], 0);
      chk("rst tdata", m_tdata[k], 8'h00);
      chk("rst busy", busy[k], 0);
      chk("rst s_tready", s_tready[k], 0);
    end
    rst = 1'b0;
    wait_cyc(1);
    chk("ready after rst", s_tready[0], 1);
    send(0, 32'h1234ABCD, 1'b0);
    chk("latency accept edge", m_tvalid[0], 0);
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      chk("streaming valid", m_tvalid[0], 1);
    end
    chk("busy during LF", busy[0], 1);
    wait_cyc(1);
    chk("busy after LF", busy[0], 0);
    chk("drain def", exp_q[0].size(), 0);
    send(1, 32'hDEADBEEF, 1'b0);
    wait_cyc(14);
    chk("drain lc", exp_q[1].size(), 0);
    m_tready[0] = 1'b0;
    send(0, 32'h0F0F0F0F, 1'b0);
    for (int i = 0; i < 800 && (exp_q[0].size() != 0 || busy[0]); i++) begin
      m_tready[0] = ($urandom_range(0, 9) < 3);
      wait_cyc(1);
    end
    m_tready[0] = 1'b1;
    chk("drain stall", exp_q[0].size(), 0);
    chk("idle after stall", busy[0], 0);
    send(0, 32'h00000000, 1'b1);
    s_tdata[0] = 32'hFFFFFFFF;
    wait_cyc(12);
    chk("b2b ready at LF", s_tready[0], 1);
    chk("b2b LF valid", m_tvalid[0], 1);
    push_word(0, 32'hFFFFFFFF);
    wait_cyc(1);
    chk("b2b gap", m_tvalid[0], 0);
    chk("b2b stalled", s_tready[0], 0);
    s_tvalid[0] = 1'b0;
    wait_cyc(1);
    chk("b2b resume", m_tvalid[0], 1);
    wait_cyc(13);
    chk("drain b2b", exp_q[0].size(), 0);
    base = hs[0];
    send(0, 32'h1234ABCD, 1'b0);
    for (int i = 0; i < 40 && hs[0] - base < 5; i++) wait_cyc(1);
    chk("five handshakes", hs[0] - base, 5);
    rst = 1'b1;
    wait_cyc(1);
    chk("mid rst tvalid", m_tvalid[0], 0);
    chk("mid rst busy", busy[0], 0);
    rst = 1'b0;
    exp_q[0].delete();
    wait_cyc(1);
    send(0, 32'h00000001, 1'b0);
    wait_cyc(14);
    chk("drain after rst", exp_q[0].size(), 0);
    send(2, 32'h0000005A, 1'b0);
    wait_cyc(1);
    chk("w8 ready low", s_tready[2], 0);
    wait_cyc(1);
    chk("w8 ready back", s_tready[2], 1);
    wait_cyc(2);
    chk("drain w8", exp_q[2].size(), 0);
    chk("w8 idle", busy[2], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
